// File: rtl/mux_n_to_1_seq_pkg.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_seq_pkg
// Shared constants for the N-to-1 registered multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   sel_width()          : select width an integrator should use for a given
//                          channel count (ceil(log2(n)), never less than 1).
// ---------------------------------------------------------------------------
package mux_n_to_1_seq_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_to_1_seq_if.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_seq_if
// Bundles the producer-side channels, mode/select controls and the
// consumer-side output of the multiplexer.
//   in_data   [CHANNELS*WIDTH] channel i at bits [i*WIDTH +: WIDTH]
//   in_valid  [CHANNELS]       per-channel valid
//   in_ready  [CHANNELS]       per-channel accept (one-hot or zero)
//   mode                       0 = fixed select, 1 = round-robin
//   sel       [SEL_W]          channel used in fixed mode
//   out_data  [WIDTH]          registered output word
//   out_chan  [SEL_W]          channel that supplied out_data
//   out_valid                  output register holds data
//   out_ready                  consumer accepts out_data
// Modports: slave = the multiplexer, master = the surrounding environment.
// ---------------------------------------------------------------------------
interface mux_n_to_1_seq_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_n_to_1_seq_rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n
// Purely combinational round-robin arbiter. Scans channels starting just
// after last_grant (wrapping at CHANNELS-1 back to 0) and grants the first
// requesting one. The grant pointer itself is owned by the parent.
//   req         [CHANNELS] request per channel
//   last_grant  [SEL_W]    most recently granted channel
//   enable                 when low, no grant is produced
//   grant_valid            some channel is granted
//   grant_idx   [SEL_W]    index of the granted channel
// ---------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last_grant,
    input  logic                enable,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (enable) begin
            // Offset 1 is the highest-priority position; offset CHANNELS
            // wraps onto last_grant itself so a lone requester still wins.
            for (int off = 1; off <= CHANNELS; off++) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!grant_valid && req[i] &&
                        (i == (int'(last_grant) + off) % CHANNELS)) begin
                        grant_valid = 1'b1;
                        grant_idx   = SEL_W'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_seq.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_seq
// N-channel registered multiplexer with valid/ready on every input channel
// and on the output. Channel choice is either an external select (fixed
// mode) or round-robin among valid channels. A single output register gives
// one cycle of latency and full throughput (it reloads while draining).
//   clock    rising-edge clock
//   reset_n  synchronous, active-low reset
//   bus      mux_n_to_1_seq_if.slave (channels, mode/sel, output)
// ---------------------------------------------------------------------------
module mux_n_to_1_seq
    import mux_n_to_1_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mux_n_to_1_seq_if.slave      bus
);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
    logic [SEL_W-1:0]    last_grant_q, last_grant_d;

    logic                load_en;
    logic                xfer;
    logic                rr_valid, fix_valid, grant_valid;
    logic [SEL_W-1:0]    rr_idx, grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic [CHANNELS-1:0] ready;

    // Reset is folded in so no channel is accepted while reset_n is low.
    assign load_en = reset_n && (!out_valid_q || bus.out_ready);

    rr_arbiter_n #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req         (bus.in_valid),
        .last_grant  (last_grant_q),
        .enable      (bus.mode == MODE_RR),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Fixed select: an out-of-range sel simply matches no channel.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((int'(bus.sel) == i) && bus.in_valid[i]) begin
                fix_valid = 1'b1;
            end
        end
    end

    assign grant_valid = (bus.mode == MODE_RR) ? rr_valid : fix_valid;
    assign grant_idx   = (bus.mode == MODE_RR) ? rr_idx   : bus.sel;
    assign xfer        = load_en && grant_valid;

    always_comb begin
        grant_data = '0;
        ready      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(grant_idx) == i) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
                ready[i]   = xfer;
            end
        end
    end

    assign bus.in_ready = ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
        // EMPTY/FULL: whenever the register may load, FULL follows the grant.
        if (load_en) begin
            out_valid_d = grant_valid;
        end
        if (xfer) begin
            out_data_d = grant_data;
            out_chan_d = grant_idx;
            // Fixed-mode transfers leave the pointer alone so RR resumes fairly.
            if (bus.mode == MODE_RR) begin
                last_grant_d = grant_idx;
            end
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_n_to_1_seq.sv
// ---------------------------------------------------------------------------
// tb_mux_n_to_1_seq
// Two instances: 4 channels x 8 bits, and 3 channels x 8 bits with a 2-bit
// select (so sel=3 is an out-of-range select). Inputs change 2 ns after the
// rising edge; outputs and in_ready are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_mux_n_to_1_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_n_to_1_seq_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus4 ();
    mux_n_to_1_seq_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) bus3 ();

    mux_n_to_1_seq #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus4)
    );

    mux_n_to_1_seq #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus3)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state of one multiplexer: output register and RR pointer.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] c;
        int         last;
    } mst_t;

    // One clock of the multiplexer at the level of the behavioural rules:
    // which channel wins this cycle, what in_ready must show, and what the
    // output register holds after the edge.
    function automatic void model_step(
        input  int          ch,
        input  mst_t        s,
        input  logic        rstn,
        input  logic        mode,
        input  logic [1:0]  sel,
        input  logic [3:0]  vld,
        input  logic [31:0] data,
        input  logic        ordy,
        output logic [3:0]  exp_rdy,
        output mst_t        ns
    );
        bit can_load;
        int g;
        ns      = s;
        exp_rdy = 4'b0000;
        if (!rstn) begin
            ns.v    = 1'b0;
            ns.d    = 8'h00;
            ns.c    = 2'd0;
            ns.last = ch - 1;
            return;
        end
        can_load = !s.v || ordy;
        g = -1;
        if (mode == 1'b0) begin
            if (int'(sel) < ch && vld[sel]) g = int'(sel);
        end else begin
            for (int k = 1; k <= ch; k++) begin
                int idx;
                idx = (s.last + k) % ch;
                if (g < 0 && vld[2'(idx)]) g = idx;
            end
        end
        if (can_load) begin
            if (g >= 0) begin
                exp_rdy[2'(g)] = 1'b1;
                ns.v = 1'b1;
                ns.d = 8'(data >> (8 * g));
                ns.c = 2'(g);
                if (mode == 1'b1) ns.last = g;
            end else begin
                ns.v = 1'b0;
            end
        end
    endfunction

    mst_t       s4 = '{1'b0, 8'h00, 2'd0, 0};
    mst_t       s3 = '{1'b0, 8'h00, 2'd0, 0};
    mst_t       ns4, ns3;
    logic [3:0] er4, er3;
    bit         known = 1'b0;

    // Compare process: every falling edge, check DUT state against the model
    // and the combinational in_ready against the model's prediction, then
    // advance the model across the coming rising edge.
    always @(negedge clk) begin
        if (known) begin
            chk("out_valid4", 32'(bus4.out_valid), 32'(s4.v));
            chk("out_data4",  32'(bus4.out_data),  32'(s4.d));
            chk("out_chan4",  32'(bus4.out_chan),  32'(s4.c));
            chk("out_valid3", 32'(bus3.out_valid), 32'(s3.v));
            chk("out_data3",  32'(bus3.out_data),  32'(s3.d));
            chk("out_chan3",  32'(bus3.out_chan),  32'(s3.c));
        end
        model_step(4, s4, rst_n, bus4.mode, bus4.sel, bus4.in_valid,
                   bus4.in_data, bus4.out_ready, er4, ns4);
        model_step(3, s3, rst_n, bus3.mode, bus3.sel, {1'b0, bus3.in_valid},
                   {8'h00, bus3.in_data}, bus3.out_ready, er3, ns3);
        if (known || !rst_n) begin
            chk("in_ready4", 32'(bus4.in_ready), 32'(er4));
            chk("in_ready3", 32'({1'b0, bus3.in_ready}), 32'(er3));
        end
        if (!rst_n) known = 1'b1;
        if (known) begin
            s4 = ns4;
            s3 = ns3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        bus4.in_data   = 32'h33221100;
        bus4.in_valid  = 4'b1111;
        bus4.mode      = 1'b1;
        bus4.sel       = 2'd0;
        bus4.out_ready = 1'b1;
        bus3.in_data   = 24'hccbbaa;
        bus3.in_valid  = 3'b111;
        bus3.mode      = 1'b0;
        bus3.sel       = 2'd0;
        bus3.out_ready = 1'b1;
        rst_n          = 1'b0;

        // Reset held two cycles with every channel valid.
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(bus4.out_valid), 0);
        chk("rst_out_data",  32'(bus4.out_data),  0);
        chk("rst_out_chan",  32'(bus4.out_chan),  0);
        chk("rst_in_ready",  32'(bus4.in_ready),  0);
        chk("rst_in_ready3", 32'(bus3.in_ready),  0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_first_ready", 32'(bus4.in_ready), 'h1);
        tick();

        // RR over all four channels: 0,1,2,3,0,1.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_all_chan", 32'(bus4.out_chan), k % 4);
            chk("rr_all_data", 32'(bus4.out_data), (k % 4) * 'h11);
            tick();
        end

        // RR over channels 2 and 3 only: 2,3,2,3.
        bus4.in_valid = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_pair_chan", 32'(bus4.out_chan), (k % 2 == 0) ? 2 : 3);
            tick();
        end

        // Fixed select of channel 2; the 3-channel DUT gets illegal sel=3.
        bus4.mode     = 1'b0;
        bus4.sel      = 2'd2;
        bus4.in_valid = 4'b1111;
        bus3.sel      = 2'd3;
        @(negedge clk);
        chk("fix_ready",     32'(bus4.in_ready),  'h4);
        chk("inv_ready3",    32'(bus3.in_ready),  0);
        chk("inv_pending3",  32'(bus3.out_valid), 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fix_data",    32'(bus4.out_data),  'h22);
            chk("fix_chan",    32'(bus4.out_chan),  2);
            chk("fix_ready",   32'(bus4.in_ready),  'h4);
            chk("inv_drained3", 32'(bus3.out_valid), 0);
            tick();
        end

        // Backpressure: load channel 1, then stall 5 cycles while sel/mode move.
        bus4.sel = 2'd1;
        tick();
        bus4.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus4.sel  = 2'(k);
            bus4.mode = k[0];
            @(negedge clk);
            chk("bp_data",  32'(bus4.out_data),  'h11);
            chk("bp_chan",  32'(bus4.out_chan),  1);
            chk("bp_valid", 32'(bus4.out_valid), 1);
            chk("bp_ready", 32'(bus4.in_ready),  0);
            tick();
        end
        bus4.out_ready = 1'b1;
        bus4.mode      = 1'b0;
        bus4.sel       = 2'd3;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus4.in_ready), 'h8);
        tick();
        @(negedge clk);
        chk("bp_next_chan", 32'(bus4.out_chan), 3);
        chk("bp_next_data", 32'(bus4.out_data), 'h33);
        tick();

        // Reset mid-stream while out_chan=2 and channel 3 would be next.
        bus4.mode = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (bus4.out_valid && bus4.out_chan == 2'd1) found = 1'b1;
            tick();
        end
        chk("mid_reach_ch1", 32'(found), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_chan_before", 32'(bus4.out_chan), 2);
        chk("mid_ready_low",   32'(bus4.in_ready), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_valid_dropped", 32'(bus4.out_valid), 0);
        chk("mid_first_ready",   32'(bus4.in_ready),  'h1);
        tick();
        @(negedge clk);
        chk("mid_first_chan", 32'(bus4.out_chan), 0);
        tick();

        // Randomized traffic, checked by the compare process every cycle.
        for (int n = 0; n < 800; n++) begin
            bus4.in_data   = $urandom;
            bus4.in_valid  = 4'($urandom_range(0, 15));
            bus4.mode      = ($urandom_range(0, 3) != 0);
            bus4.sel       = 2'($urandom_range(0, 3));
            bus4.out_ready = ($urandom_range(0, 3) != 0);
            bus3.in_data   = 24'($urandom);
            bus3.in_valid  = 3'($urandom_range(0, 7));
            bus3.mode      = ($urandom_range(0, 1) != 0);
            bus3.sel       = 2'($urandom_range(0, 3));
            bus3.out_ready = ($urandom_range(0, 3) != 0);
            rst_n          = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
